pwm_capture: RTL and testbench

- Input-capture receiver for PWM waveforms: measures period and high time of an external PWM signal in prescaled clock ticks.
- Counterpart of the team's APB4 PWM generator. Used for loopback self-test of generator outputs and for decoding external PWM sensors and fan tachometers.
- Results leave through a one-entry valid/ready port; a later APB4 wrapper maps that port onto registers and an IRQ.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_cap_edge.sv | 38 +++
 rtl/pwm_capture.sv | 133 +++++++++++++
 tb/tb_pwm_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM input-capture block.
package pwm_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned PSC_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_e;

  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0] period;
    logic [CNT_WIDTH_DEF-1:0] high;
    logic                     ovf;
  } cap_t;

endpackage

// File: rtl/pwm_cap_edge.sv
// Input conditioning for pwm_capture: synchronizer, polarity select and
// rising-edge detect on the conditioned signal.
module pwm_cap_edge
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pol_i,
  input  logic pwm_i,
  output logic prev_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_i};
    s      = sync_q[SYNC_STAGES-1] ^ pol_i;
    prev_d = s;
    rise_o = s & ~prev_q;
    prev_o = prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and active time in prescaled ticks and
// presents each result on a one-entry valid/ready holding register.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned PSC_WIDTH   = PSC_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 pol_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic                 pwm_i,
  output logic                 cap_valid_o,
  input  logic                 cap_ready_i,
  output logic [CNT_WIDTH-1:0] cap_period_o,
  output logic [CNT_WIDTH-1:0] cap_high_o,
  output logic                 cap_ovf_o,
  output logic                 drop_o
);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high;
    logic                 ovf;
  } res_t;

  logic rise, prev;

  pwm_cap_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .pol_i  (pol_i),
    .pwm_i  (pwm_i),
    .prev_o (prev),
    .rise_o (rise)
  );

  state_e               state_q, state_d;
  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d, psc_last;
  logic [CNT_WIDTH-1:0] period_q, period_d, period_inc;
  logic [CNT_WIDTH-1:0] high_q, high_d, high_inc;
  res_t                 hold_q, hold_d, cap_res;
  logic                 valid_q, valid_d, drop_q, drop_d;
  logic                 tick, cap_evt, accept;

  always_comb begin
    psc_last   = (psc_i == '0) ? '0 : psc_i - PSC_WIDTH'(1);
    tick       = (psc_cnt_q == psc_last);
    period_inc = (tick && period_q != '1) ? period_q + CNT_WIDTH'(1) : period_q;
    high_inc   = (tick && prev && high_q != '1) ? high_q + CNT_WIDTH'(1) : high_q;
  end

  // Counters default to zero so any state other than a running MEAS clears them.
  always_comb begin
    state_d   = state_q;
    psc_cnt_d = '0;
    period_d  = '0;
    high_d    = '0;
    cap_evt   = 1'b0;
    cap_res   = '0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM:  if (rise) state_d = MEAS;
        MEAS: begin
          cap_res.period = period_inc;
          cap_res.high   = high_inc;
          cap_res.ovf    = ~rise;
          if (rise) begin
            cap_evt = 1'b1;
          end else if (period_inc == '1) begin
            cap_evt = 1'b1;
            state_d = ARM;
          end else begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_WIDTH'(1);
            period_d  = period_inc;
            high_d    = high_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept  = valid_q & cap_ready_i;
    hold_d  = hold_q;
    valid_d = valid_q & ~accept;
    drop_d  = 1'b0;
    if (cap_evt) begin
      if (!valid_q || accept) begin
        hold_d  = cap_res;
        valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      psc_cnt_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_cnt_q <= psc_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign cap_valid_o  = valid_q;
  assign cap_period_o = hold_q.period;
  assign cap_high_o   = hold_q.high;
  assign cap_ovf_o    = hold_q.ovf;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_capture;

  localparam int unsigned CW   = 8;
  localparam int unsigned SS   = 2;
  localparam int          MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n_i, en_i, pol_i, pwm_i, cap_ready_i;
  logic [15:0]   psc_i;
  logic          cap_valid_o, cap_ovf_o, drop_o;
  logic [CW-1:0] cap_period_o, cap_high_o;

  pwm_capture #(
    .CNT_WIDTH  (CW),
    .PSC_WIDTH  (16),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .pol_i       (pol_i),
    .psc_i       (psc_i),
    .pwm_i       (pwm_i),
    .cap_valid_o (cap_valid_o),
    .cap_ready_i (cap_ready_i),
    .cap_period_o(cap_period_o),
    .cap_high_o  (cap_high_o),
    .cap_ovf_o   (cap_ovf_o),
    .drop_o      (drop_o)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from rise/fall timestamps of the conditioned input.
  bit pq[$];
  int mode = 0, t0 = 0, tf = -1, edge_n = 0, n_div = 1;
  int exp_valid = 0, exp_per = 0, exp_high = 0, exp_ovf = 0, exp_drop = 0;
  int c_per, c_high, c_ovf;
  bit s, pv, rise, cap;

  always @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pq.delete();
      for (int i = 0; i < int'(SS) + 2; i++) pq.push_back(1'b0);
      mode = 0; t0 = 0; tf = -1; edge_n = 0;
      exp_valid = 0; exp_per = 0; exp_high = 0; exp_ovf = 0; exp_drop = 0;
    end else begin
      edge_n++;
      n_div = (psc_i == 0) ? 1 : int'(psc_i);
      pq.push_front(pwm_i);
      void'(pq.pop_back());
      s    = pq[SS] ^ pol_i;
      pv   = pq[SS+1] ^ pol_i;
      rise = s & !pv;
      cap  = 0;
      if (!en_i) mode = 0;
      else if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (rise) begin mode = 2; t0 = edge_n; tf = -1; end
      end else begin
        if (rise) begin
          cap = 1; c_ovf = 0;
          c_per  = (edge_n - t0) / n_div;
          c_high = (((tf < 0) ? edge_n : tf) - t0) / n_div;
          t0 = edge_n; tf = -1;
        end else begin
          if (!s && tf < 0) tf = edge_n;
          if (edge_n - t0 == MAXV * n_div) begin
            cap = 1; c_ovf = 1; c_per = MAXV;
            c_high = (((tf < 0) ? edge_n : tf) - t0) / n_div;
            mode = 1;
          end
        end
      end
      exp_drop = 0;
      if (cap) begin
        if (!exp_valid || cap_ready_i) begin
          exp_valid = 1; exp_per = c_per; exp_high = c_high; exp_ovf = c_ovf;
        end else exp_drop = 1;
      end else if (exp_valid && cap_ready_i) exp_valid = 0;
    end
  end

  always @(negedge clk) begin
    check("valid", cap_valid_o, exp_valid);
    check("drop", drop_o, exp_drop);
    if (exp_valid != 0) begin
      check("period", cap_period_o, exp_per);
      check("high", cap_high_o, exp_high);
      check("ovf", cap_ovf_o, exp_ovf);
    end
  end

  int acc_n = 0, drop_n = 0, acc_per = 0, acc_high = 0, acc_ovf = 0;
  always @(posedge clk) begin
    if (rst_n_i) begin
      if (cap_valid_o && cap_ready_i) begin
        acc_n++; acc_per = cap_period_o; acc_high = cap_high_o; acc_ovf = cap_ovf_o;
      end
      if (drop_o) drop_n++;
    end
  end

  bit rand_ready = 0;
  int a0, d0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) cap_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wave(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      pwm_i = 1'b1; step(hi);
      pwm_i = 1'b0; step(per - hi);
    end
  endtask

  task automatic reconfig(input int psc, input int pol);
    en_i = 1'b0; step(2);
    psc_i = 16'(psc); pol_i = 1'(pol); step(1);
    en_i = 1'b1; step(3);
  endtask

  task automatic expect_results(input string tag, input int cnt, input int per,
                                input int hi, input int ovf);
    check({tag, "_count"}, acc_n - a0, cnt);
    check({tag, "_period"}, acc_per, per);
    check({tag, "_high"}, acc_high, hi);
    check({tag, "_ovf"}, acc_ovf, ovf);
  endtask

  initial begin
    rst_n_i = 1'b0; en_i = 1'b0; pol_i = 1'b0; psc_i = 16'd1;
    pwm_i = 1'b0; cap_ready_i = 1'b0;
    step(3);
    check("rst_valid", cap_valid_o, 0);
    check("rst_period", cap_period_o, 0);
    check("rst_drop", drop_o, 0);
    rst_n_i = 1'b1; step(2);

    cap_ready_i = 1'b1; en_i = 1'b1; step(3);
    a0 = acc_n; wave(10, 3, 4); step(8);
    expect_results("psc1", 3, 10, 3, 0);

    reconfig(4, 0); a0 = acc_n; wave(40, 12, 4); step(8);
    expect_results("psc4", 3, 10, 3, 0);

    reconfig(0, 0); a0 = acc_n; wave(10, 3, 4); step(8);
    expect_results("psc0", 3, 10, 3, 0);

    reconfig(1, 1); a0 = acc_n; wave(10, 3, 4); step(8);
    expect_results("pol1", 3, 10, 7, 0);

    // Back-pressure: first result held, two later ones dropped.
    reconfig(1, 0); cap_ready_i = 1'b0; d0 = drop_n;
    wave(10, 3, 2); wave(12, 5, 2); step(5);
    check("bp_drops", drop_n - d0, 2);
    check("bp_valid", cap_valid_o, 1);
    check("bp_period", cap_period_o, 10);
    check("bp_high", cap_high_o, 3);
    cap_ready_i = 1'b1; step(1); cap_ready_i = 1'b0;
    check("bp_release", cap_valid_o, 0);

    // Capture lands on the same edge as the accept of the held result.
    reconfig(1, 0); cap_ready_i = 1'b0;
    wave(14, 4, 1); wave(9, 2, 1);
    check("co_held", cap_period_o, 14);
    pwm_i = 1'b1; step(2); cap_ready_i = 1'b1; step(1); cap_ready_i = 1'b0;
    check("co_valid", cap_valid_o, 1);
    check("co_period", cap_period_o, 9);
    check("co_high", cap_high_o, 2);
    step(1); pwm_i = 1'b0; step(6); cap_ready_i = 1'b1; step(3);

    reconfig(1, 0); cap_ready_i = 1'b1; a0 = acc_n;
    pwm_i = 1'b1; step(300);
    expect_results("stuck", 1, MAXV, MAXV, 1);
    a0 = acc_n; wave(20, 5, 3); step(8);
    expect_results("resume", 1, 20, 5, 0);

    reconfig(1, 0); cap_ready_i = 1'b0;
    wave(10, 3, 2); pwm_i = 1'b1; step(2);
    rst_n_i = 1'b0; #1;
    check("arst_valid", cap_valid_o, 0);
    check("arst_period", cap_period_o, 0);
    check("arst_high", cap_high_o, 0);
    step(2); pwm_i = 1'b0; rst_n_i = 1'b1; step(2);
    cap_ready_i = 1'b1; a0 = acc_n; wave(10, 3, 3); step(8);
    expect_results("post_rst", 2, 10, 3, 0);

    // Disable mid-period with a pending result.
    reconfig(1, 0); cap_ready_i = 1'b0; d0 = drop_n;
    wave(10, 3, 1); pwm_i = 1'b1; step(3); pwm_i = 1'b0; step(2);
    en_i = 1'b0; step(3); wave(10, 3, 3);
    check("dis_valid", cap_valid_o, 1);
    check("dis_period", cap_period_o, 10);
    check("dis_high", cap_high_o, 3);
    check("dis_drops", drop_n - d0, 0);
    cap_ready_i = 1'b1; step(1); cap_ready_i = 1'b0;
    check("dis_consumed", cap_valid_o, 0);
    en_i = 1'b1; step(2); cap_ready_i = 1'b1; a0 = acc_n;
    wave(10, 3, 3); step(8);
    expect_results("reen", 2, 10, 3, 0);

    rand_ready = 1;
    for (int it = 0; it < 40; it++) begin
      reconfig($urandom_range(0, 4), $urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(2, 6)); k++) begin
        int per, hi;
        per = $urandom_range(3, 60);
        hi  = $urandom_range(1, per - 1);
        wave(per, hi, 1);
      end
    end
    rand_ready = 0; cap_ready_i = 1'b1; step(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
